// File: rtl/word_byte_serializer.sv
// Splits an accepted 32-bit word into four bytes on a valid/ready byte stream.
// Lane order is set by MSB_FIRST; back-to-back words stream without a bubble.
module word_byte_serializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        abort,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic [1:0]  out_idx,
  output logic        out_last,
  output logic        busy
);

  // state | meaning
  // IDLE  | no word held, ready to accept
  // SEND  | word held, emitting byte idx
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  lane;
  logic        fire;
  logic        idx_end;

  assign idx_end = (idx_q == 2'd3);
  assign fire    = (state_q == SEND) && out_ready && !abort;

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    idx_d    = idx_q;
    in_ready = !abort && ((state_q == IDLE) || (fire && idx_end));
    if (abort) begin
      state_d = IDLE;
      idx_d   = 2'd0;
    end else if (state_q == IDLE) begin
      if (in_valid) begin
        word_d  = in_data;
        idx_d   = 2'd0;
        state_d = SEND;
      end
    end else if (fire) begin
      if (!idx_end) begin
        idx_d = idx_q + 2'd1;
      end else if (in_valid) begin
        word_d = in_data;
        idx_d  = 2'd0;
      end else begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= 32'd0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
    end
  end

  // Lane 0 is [31:24]; LSB-first order walks the lanes backwards.
  assign lane = MSB_FIRST ? idx_q : (2'd3 - idx_q);

  always_comb begin
    out_byte = 8'h00;
    if (state_q == SEND) begin
      case (lane)
        2'd0:    out_byte = word_q[31:24];
        2'd1:    out_byte = word_q[23:16];
        2'd2:    out_byte = word_q[15:8];
        default: out_byte = word_q[7:0];
      endcase
    end
  end

  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_idx   = idx_q;
  assign out_last  = (state_q == SEND) && idx_end;

endmodule

// File: tb/tb_word_byte_serializer.sv
// Self-checking bench: directed vector table, hand sequences for abort/reset,
// and randomized traffic against a word/byte-count reference model.
module tb_word_byte_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        abort;
  logic        out_ready;

  logic        in_ready_m, out_valid_m, out_last_m, busy_m;
  logic [7:0]  out_byte_m;
  logic [1:0]  out_idx_m;
  logic        in_ready_l, out_valid_l, out_last_l, busy_l;
  logic [7:0]  out_byte_l;
  logic [1:0]  out_idx_l;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: held word, count of bytes already taken
  bit          m_have;
  logic [31:0] m_w;
  int          m_sent;

  always #5 clk = ~clk;

  word_byte_serializer #(.MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_data(in_data), .abort(abort), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_byte(out_byte_m), .out_idx(out_idx_m), .out_last(out_last_m), .busy(busy_m)
  );

  word_byte_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_data(in_data), .abort(abort), .out_valid(out_valid_l), .out_ready(out_ready),
    .out_byte(out_byte_l), .out_idx(out_idx_l), .out_last(out_last_l), .busy(busy_l)
  );

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ab;
    logic        ordy;
    logic        ev;
    logic [7:0]  eb;
    logic [1:0]  ei;
    logic        el;
    logic        eir;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic ab, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    abort     = ab;
    out_ready = ordy;
    #1;
  endtask

  task automatic model_step();
    if (abort) begin
      m_have = 1'b0;
      m_sent = 0;
    end else if (m_have) begin
      if (out_ready) begin
        m_sent++;
        if (m_sent == 4) begin
          m_sent = 0;
          if (in_valid) m_w = in_data;
          else m_have = 1'b0;
        end
      end
    end else if (in_valid) begin
      m_have = 1'b1;
      m_w    = in_data;
      m_sent = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  task automatic check_model();
    logic [7:0] eb_m, eb_l;
    logic       eir;
    eb_m = m_have ? 8'((m_w >> (8 * (3 - m_sent))) & 32'hFF) : 8'h00;
    eb_l = m_have ? 8'((m_w >> (8 * m_sent)) & 32'hFF) : 8'h00;
    eir  = !abort && (!m_have || (out_ready && m_sent == 3));
    chk("rnd_valid",   32'(out_valid_m), 32'(m_have));
    chk("rnd_busy",    32'(busy_m),      32'(m_have));
    chk("rnd_byte",    32'(out_byte_m),  32'(eb_m));
    chk("rnd_idx",     32'(out_idx_m),   32'(m_sent));
    chk("rnd_last",    32'(out_last_m),  32'(m_have && m_sent == 3));
    chk("rnd_inready", 32'(in_ready_m),  32'(eir));
    chk("rnd_lsb_valid",   32'(out_valid_l), 32'(m_have));
    chk("rnd_lsb_byte",    32'(out_byte_l),  32'(eb_l));
    chk("rnd_lsb_idx",     32'(out_idx_l),   32'(m_sent));
    chk("rnd_lsb_last",    32'(out_last_l),  32'(m_have && m_sent == 3));
    chk("rnd_lsb_inready", 32'(in_ready_l),  32'(eir));
  endtask

  vec_t       tbl [24];
  logic [7:0] exp5 [6];
  logic       last5 [6];
  logic [7:0] exp6 [4];

  initial begin
    tbl[0]  = '{1'b1, 32'hA1B2C3D4, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 8'hA1, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 8'hB2, 2'd1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 8'hC3, 2'd2, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 8'hD4, 2'd3, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 32'hA1B2C3D4, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 8'hA1, 2'd0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'hB2, 2'd1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'hB2, 2'd1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'hB2, 2'd1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 8'hB2, 2'd1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 8'hC3, 2'd2, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 8'hD4, 2'd3, 1'b1, 1'b1};
    tbl[14] = '{1'b1, 32'h11223344, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 32'h55667788, 1'b0, 1'b1, 1'b1, 8'h11, 2'd0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 32'h55667788, 1'b0, 1'b1, 1'b1, 8'h22, 2'd1, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 32'h55667788, 1'b0, 1'b1, 1'b1, 8'h33, 2'd2, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 32'h55667788, 1'b0, 1'b1, 1'b1, 8'h44, 2'd3, 1'b1, 1'b1};
    tbl[19] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 8'h55, 2'd0, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 8'h66, 2'd1, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 8'h77, 2'd2, 1'b0, 1'b0};
    tbl[22] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 8'h88, 2'd3, 1'b1, 1'b1};
    tbl[23] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1};
    exp5  = '{8'h00, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h00};
    last5 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp6  = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; abort = 1'b0; out_ready = 1'b0;
    m_have = 1'b0; m_w = 32'h0; m_sent = 0;
    #12;
    chk("rst_valid",   32'(out_valid_m), 32'd0);
    chk("rst_byte",    32'(out_byte_m),  32'd0);
    chk("rst_idx",     32'(out_idx_m),   32'd0);
    chk("rst_last",    32'(out_last_m),  32'd0);
    chk("rst_busy",    32'(busy_m),      32'd0);
    chk("rst_inready", 32'(in_ready_m),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // directed vectors: single word, backpressure, back-to-back
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].ab, tbl[i].ordy);
      chk($sformatf("vec%0d_valid", i),   32'(out_valid_m), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_busy", i),    32'(busy_m),      32'(tbl[i].ev));
      chk($sformatf("vec%0d_byte", i),    32'(out_byte_m),  32'(tbl[i].eb));
      chk($sformatf("vec%0d_idx", i),     32'(out_idx_m),   32'(tbl[i].ei));
      chk($sformatf("vec%0d_last", i),    32'(out_last_m),  32'(tbl[i].el));
      chk($sformatf("vec%0d_inready", i), 32'(in_ready_m),  32'(tbl[i].eir));
      tick();
    end

    // LSB-first ordering
    for (int i = 0; i < 6; i++) begin
      drive(i == 0, 32'hA1B2C3D4, 1'b0, 1'b1);
      chk($sformatf("lsb%0d_byte", i), 32'(out_byte_l), 32'(exp5[i]));
      chk($sformatf("lsb%0d_last", i), 32'(out_last_l), 32'(last5[i]));
      tick();
    end

    // abort after B2 taken, with a competing word offered
    drive(1'b1, 32'hA1B2C3D4, 1'b0, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk("abt_a1", 32'(out_byte_m), 32'hA1); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk("abt_b2", 32'(out_byte_m), 32'hB2); tick();
    drive(1'b1, 32'hCAFEF00D, 1'b1, 1'b1);
    chk("abt_inready_low", 32'(in_ready_m), 32'd0);
    chk("abt_c3_shown",    32'(out_byte_m), 32'hC3);
    tick();
    drive(1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
    chk("abt_idle_valid",   32'(out_valid_m), 32'd0);
    chk("abt_idle_inready", 32'(in_ready_m),  32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      chk($sformatf("abt_byte%0d", i), 32'(out_byte_m), 32'(exp6[i]));
      chk($sformatf("abt_last%0d", i), 32'(out_last_m), 32'(i == 3));
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk("abt_end_valid", 32'(out_valid_m), 32'd0);
    tick();

    // asynchronous reset mid-word
    drive(1'b1, 32'h12345678, 1'b0, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk("mid_byte_before", 32'(out_byte_m), 32'h12);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",   32'(out_valid_m), 32'd0);
    chk("mid_rst_byte",    32'(out_byte_m),  32'd0);
    chk("mid_rst_busy",    32'(busy_m),      32'd0);
    chk("mid_rst_inready", 32'(in_ready_m),  32'd1);
    chk("mid_rst_lsb_valid", 32'(out_valid_l), 32'd0);
    m_have = 1'b0; m_sent = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 7);
      check_model();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
